// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Optional build macro: HAZARD_PERF_EN (adds stall/flush performance counters to the top).
package hazard_ctrl_pkg;

    typedef logic [4:0] creg_addr_t;

    typedef enum logic {MdIdle, MdBusy} md_state_t;
    typedef enum logic {DIdle, DWait}   d_state_t;

    localparam int unsigned DivCyclesDefault  = 32;
    localparam int unsigned MultCyclesDefault = 4;

    // Register r0 is hard-wired zero, so writing it never creates a dependency.
    function automatic logic src_match(creg_addr_t dst, creg_addr_t rs, creg_addr_t rt);
        return (dst != '0) && ((dst == rs) || (dst == rt));
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_counter.sv
// Mult/div occupancy tracker: holds E busy for DIV_CYCLES or MULT_CYCLES cycles
// including the issue cycle. An abort drops straight back to idle.
module md_busy_counter
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES  = DivCyclesDefault,
    parameter int unsigned MULT_CYCLES = MultCyclesDefault
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic isdiv_i,
    input  logic abort_i,
    output logic busy_o
);

    localparam int unsigned MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 2) ? $clog2(MaxCycles) : 1;

    localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES - 1);
    localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES - 1);
    localparam logic [CntW-1:0] CntLast  = CntW'(1);

    md_state_t       state_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || abort_i) begin
            state_q <= MdIdle;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                MdIdle: begin
                    if (start_i) begin
                        state_q <= MdBusy;
                        cnt_q   <= isdiv_i ? DivLoad : MultLoad;
                    end
                end
                MdBusy: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CntLast) begin
                        state_q <= MdIdle;
                    end
                end
                default: begin
                    state_q <= MdIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // The issue cycle counts as busy, so the idle-state start is folded in combinationally.
    assign busy_o = (state_q == MdBusy) || ((state_q == MdIdle) && start_i);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush generation for the five pipeline registers.
// Optional build macro: HAZARD_PERF_EN (adds perf_stall_cyc / perf_flush_cnt outputs).
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES  = DivCyclesDefault,
    parameter int unsigned MULT_CYCLES = MultCyclesDefault
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic        branchD,
    input  logic [4:0]  writeregE,
    input  logic        regwriteE,
    input  logic        memtoregE,
    input  logic [4:0]  writeregM,
    input  logic        regwriteM,
    input  logic        memtoregM,
    input  logic        mdstartE,
    input  logic        mdisdivE,
    input  logic        i_req,
    input  logic        i_data_ok,
    input  logic        d_reqM,
    input  logic        d_data_ok,
    input  logic        excM,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        stallM,
    output logic        flushD,
    output logic        flushE,
    output logic        flushM,
    output logic        flushW,
    output logic        md_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall_cyc,
    output logic [31:0] perf_flush_cnt
`endif
);

    d_state_t d_state_q;
    logic     lwstall, brstall, ldbr, dwait, exc, fwait, md_raw, md_stall;

    // Branch stalls only key off a load in M; ALU results in M are forwarded.
    logic unused_regwrite_m;
    assign unused_regwrite_m = regwriteM;

    assign lwstall = regwriteE & memtoregE & src_match(writeregE, rsD, rtD);
    assign brstall = branchD & ((regwriteE & src_match(writeregE, rsD, rtD)) |
                                (memtoregM & src_match(writeregM, rsD, rtD)));
    assign ldbr    = lwstall | brstall;
    assign fwait   = i_req & ~i_data_ok;
    assign dwait   = (((d_state_q == DIdle) & d_reqM) | (d_state_q == DWait)) & ~d_data_ok;
    assign exc     = excM & ~dwait;

    md_busy_counter #(
        .DIV_CYCLES  (DIV_CYCLES),
        .MULT_CYCLES (MULT_CYCLES)
    ) u_md_busy_counter (
        .clk     (clk),
        .reset   (reset),
        .start_i (mdstartE),
        .isdiv_i (mdisdivE),
        .abort_i (exc),
        .busy_o  (md_raw)
    );

    assign md_stall = md_raw & ~reset;
    assign md_busy  = md_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            d_state_q <= DIdle;
        end else begin
            unique case (d_state_q)
                DIdle:   if (d_reqM && !d_data_ok) d_state_q <= DWait;
                DWait:   if (d_data_ok) d_state_q <= DIdle;
                default: d_state_q <= DIdle;
            endcase
        end
    end

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        flushW = 1'b0;
        if (!reset) begin
            if (dwait) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end else if (exc) begin
                flushD = 1'b1;
                flushE = 1'b1;
                flushM = 1'b1;
                flushW = 1'b1;
            end else begin
                stallF = md_stall | ldbr | fwait;
                stallD = md_stall | ldbr;
                stallE = md_stall;
                flushM = md_stall;
                // Never flush a stage that a higher-priority rule is holding.
                flushE = ldbr & ~md_stall;
                flushD = fwait & ~(md_stall | ldbr);
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_q + 32'(stallF);
            perf_flush_q <= perf_flush_q + 32'(flushE | flushM | flushW);
        end
    end

    assign perf_stall_cyc = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic against a priority-rule model.
module tb_hazard_ctrl;

    localparam int DivN  = 32;
    localparam int MultN = 4;

    logic       clk, reset;
    logic [4:0] rsD, rtD, writeregE, writeregM;
    logic       branchD, regwriteE, memtoregE, regwriteM, memtoregM;
    logic       mdstartE, mdisdivE, i_req, i_data_ok, d_reqM, d_data_ok, excM;
    logic       stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW, md_busy;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cyc, perf_flush_cnt;
`endif

    hazard_ctrl #(
        .DIV_CYCLES  (DivN),
        .MULT_CYCLES (MultN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rsD       (rsD),
        .rtD       (rtD),
        .branchD   (branchD),
        .writeregE (writeregE),
        .regwriteE (regwriteE),
        .memtoregE (memtoregE),
        .writeregM (writeregM),
        .regwriteM (regwriteM),
        .memtoregM (memtoregM),
        .mdstartE  (mdstartE),
        .mdisdivE  (mdisdivE),
        .i_req     (i_req),
        .i_data_ok (i_data_ok),
        .d_reqM    (d_reqM),
        .d_data_ok (d_data_ok),
        .excM      (excM),
        .stallF    (stallF),
        .stallD    (stallD),
        .stallE    (stallE),
        .stallM    (stallM),
        .flushD    (flushD),
        .flushE    (flushE),
        .flushM    (flushM),
        .flushW    (flushW),
        .md_busy   (md_busy)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cyc (perf_stall_cyc),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: remaining busy cycles of the mult/div unit and an outstanding data access.
    int          md_left      = 0;
    bit          mem_pending  = 0;
    int unsigned model_stalls = 0;
    int unsigned model_flush  = 0;
    logic [8:0]  obs;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit hits(input logic [4:0] w);
        return (w != 0) && (w == rsD || w == rtD);
    endfunction

    function automatic bit mem_wait();
        return (mem_pending || d_reqM) && !d_data_ok;
    endfunction

    // Returns {md_busy, stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW}.
    function automatic logic [8:0] expect_out();
        bit md, lw, br, fw;
        logic [7:0] o;
        if (reset) return 9'd0;
        md = (md_left > 0) || mdstartE;
        lw = regwriteE && memtoregE && hits(writeregE);
        br = branchD && ((regwriteE && hits(writeregE)) || (memtoregM && hits(writeregM)));
        fw = i_req && !i_data_ok;
        if (mem_wait())    o = 8'b1111_0001;
        else if (excM)     o = 8'b0000_1111;
        else if (md)       o = 8'b1110_0010;
        else if (lw || br) o = 8'b1100_0100;
        else if (fw)       o = 8'b1000_1000;
        else               o = 8'b0000_0000;
        return {md, o};
    endfunction

    task automatic clear_inputs();
        {rsD, rtD, writeregE, writeregM} = '0;
        {branchD, regwriteE, memtoregE, regwriteM, memtoregM} = '0;
        {mdstartE, mdisdivE, i_req, i_data_ok, d_reqM, d_data_ok, excM} = '0;
    endtask

    // Inputs are held from just after one edge through the next; check mid-cycle, then advance.
    task automatic step(input string tag);
        logic [8:0] e;
        bit         dw;
        #3;
        e   = expect_out();
        obs = {md_busy, stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW};
        check_eq({tag, "_outs"}, 32'(obs), 32'(e));
`ifdef HAZARD_PERF_EN
        check_eq({tag, "_perf_stall"}, perf_stall_cyc, model_stalls);
        check_eq({tag, "_perf_flush"}, perf_flush_cnt, model_flush);
`endif
        @(posedge clk);
        if (reset) begin
            md_left = 0;
            mem_pending = 0;
            model_stalls = 0;
            model_flush = 0;
        end else begin
            dw = mem_wait();
            model_stalls += 32'(e[7]);
            model_flush  += 32'(e[2] | e[1] | e[0]);
            mem_pending = dw;
            if (excM && !dw)      md_left = 0;
            else if (md_left > 0) md_left--;
            else if (mdstartE)    md_left = (mdisdivE ? DivN : MultN) - 1;
        end
        #1;
    endtask

    int cnt_e, cnt_b, cnt_m;

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        step("reset0");
        step("reset1");
        reset = 1'b0;
        step("idle");

        // Load-use: lw r2 in E, consumer of r2 in D.
        regwriteE = 1; memtoregE = 1; writeregE = 5'd2; rsD = 5'd2;
        step("loaduse");
        check_eq("loaduse_flushE", 32'(obs[2]), 32'd1);
        clear_inputs();
        step("loaduse_clean");

        // Divide occupies E for DivN cycles.
        mdstartE = 1; mdisdivE = 1;
        cnt_e = 0; cnt_b = 0;
        for (int i = 0; i < DivN + 6; i++) begin
            step("div");
            mdstartE = 0;
            cnt_e += int'(obs[5]);
            cnt_b += int'(obs[8]);
        end
        check_eq("div_stallE_cycles", 32'(cnt_e), 32'(DivN));
        check_eq("div_busy_cycles", 32'(cnt_b), 32'(DivN));

        // Data access completing three cycles after issue.
        d_reqM = 1;
        cnt_m = 0;
        for (int i = 0; i < 3; i++) begin
            step("dwait");
            cnt_m += int'(obs[4]);
        end
        d_data_ok = 1;
        step("dwait_ok");
        check_eq("dwait_stallM_cycles", 32'(cnt_m), 32'd3);
        check_eq("dwait_ok_stalls", 32'(obs[7:4]), 32'd0);
        clear_inputs();
        step("dwait_done");

        // Exception while the divider has 10 cycles left.
        mdstartE = 1; mdisdivE = 1;
        for (int i = 0; i < DivN && md_left != 10; i++) begin
            step("exc_md_run");
            mdstartE = 0;
        end
        check_eq("exc_md_reached10", 32'(md_left), 32'd10);
        excM = 1;
        step("exc_md");
        check_eq("exc_md_flushes", 32'(obs[3:0]), 32'hf);
        excM = 0;
        step("exc_md_after");
        check_eq("exc_md_busy_after", 32'(obs[8]), 32'd0);

        // Exception held off behind a data wait.
        d_reqM = 1;
        step("exc_dw0");
        excM = 1;
        step("exc_dw1");
        check_eq("exc_dw_noflushD", 32'(obs[3]), 32'd0);
        step("exc_dw2");
        d_data_ok = 1;
        step("exc_dw_ok");
        check_eq("exc_dw_flushD", 32'(obs[3]), 32'd1);
        clear_inputs();
        step("exc_dw_done");

        // Reset in the middle of a divide and a data wait.
        mdstartE = 1; mdisdivE = 1; d_reqM = 1;
        step("mid0");
        mdstartE = 0;
        step("mid1");
        step("mid2");
        reset = 1;
        step("mid_reset");
        reset = 0;
        clear_inputs();
        step("post_reset");
        check_eq("post_reset_quiet", 32'(obs), 32'd0);

        // Randomized traffic with small register indices so dependencies are frequent.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            rsD       = 5'($urandom_range(0, 3));
            rtD       = 5'($urandom_range(0, 3));
            writeregE = 5'($urandom_range(0, 3));
            writeregM = 5'($urandom_range(0, 3));
            branchD   = $urandom_range(0, 2) == 0;
            regwriteE = $urandom_range(0, 1) == 1;
            memtoregE = $urandom_range(0, 2) == 0;
            regwriteM = $urandom_range(0, 1) == 1;
            memtoregM = $urandom_range(0, 2) == 0;
            mdstartE  = $urandom_range(0, 24) == 0;
            mdisdivE  = $urandom_range(0, 3) == 0;
            i_req     = $urandom_range(0, 1) == 1;
            i_data_ok = $urandom_range(0, 1) == 1;
            d_reqM    = $urandom_range(0, 3) == 0;
            d_data_ok = $urandom_range(0, 2) == 0;
            excM      = $urandom_range(0, 29) == 0;
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
